// File: rtl/tmds_enc_mc.sv
// Multi-channel DC-balanced TMDS encoder: shared-latency pipeline, one lane per channel.
// Optional TMDS_DISP_MON_EN exposes each lane's running disparity on disp_o.
module tmds_lane #(
  parameter int OUT_REG = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] d_i,
  input  logic [1:0] c_i,
  input  logic       vld_i,   // valid aligned with the stage-3 inputs
`ifdef TMDS_DISP_MON_EN
  output logic [4:0] cnt_o,
`endif
  output logic [9:0] out_o
);
  logic [7:0] d1_q;
  logic [3:0] n1_q;
  logic [1:0] c1_q, c2_q, c3;
  logic [8:0] qm_d, qm2_q, qm3;
  logic [3:0] ones_d, ones2_q, ones3;
  logic [9:0] out_d, out_q;
  logic signed [4:0] cnt_d, cnt_q, diff;

  always_comb begin
    logic       xn;
    logic [7:0] q;
    xn   = (n1_q > 4'd4) || (n1_q == 4'd4 && !d1_q[0]);
    q    = '0;
    q[0] = d1_q[0];
    for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d1_q[i] ^ xn;
    qm_d   = {~xn, q};
    ones_d = 4'($countones(q));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d1_q <= '0; n1_q <= '0; c1_q <= '0;
      qm2_q <= '0; ones2_q <= '0; c2_q <= '0;
    end else begin
      d1_q <= d_i; n1_q <= 4'($countones(d_i)); c1_q <= c_i;
      qm2_q <= qm_d; ones2_q <= ones_d; c2_q <= c1_q;
    end
  end

  // Extra register sits before the disparity stage so that cnt stays in the output flop.
  if (OUT_REG != 0) begin : g_oreg
    logic [8:0] qm3_q;
    logic [3:0] ones3_q;
    logic [1:0] c3_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        qm3_q <= '0; ones3_q <= '0; c3_q <= '0;
      end else begin
        qm3_q <= qm2_q; ones3_q <= ones2_q; c3_q <= c2_q;
      end
    end
    assign qm3 = qm3_q; assign ones3 = ones3_q; assign c3 = c3_q;
  end else begin : g_noreg
    assign qm3 = qm2_q; assign ones3 = ones2_q; assign c3 = c2_q;
  end

  always_comb begin
    diff  = {ones3, 1'b0} - 5'd8;   // N1 - N0, mod 32
    out_d = 10'h354;
    cnt_d = cnt_q;
    if (!vld_i) begin
      cnt_d = '0;
      case (c3)
        2'b00:   out_d = 10'h354;
        2'b01:   out_d = 10'h0AB;
        2'b10:   out_d = 10'h154;
        default: out_d = 10'h2AB;
      endcase
    end else if (cnt_q == 5'sd0 || diff == 5'sd0) begin
      out_d = {~qm3[8], qm3[8], qm3[8] ? qm3[7:0] : ~qm3[7:0]};
      cnt_d = qm3[8] ? cnt_q + diff : cnt_q - diff;
    end else if ((cnt_q > 0 && diff > 0) || (cnt_q < 0 && diff < 0)) begin
      out_d = {1'b1, qm3[8], ~qm3[7:0]};
      cnt_d = cnt_q + $signed({3'b000, qm3[8], 1'b0}) - diff;
    end else begin
      out_d = {1'b0, qm3[8], qm3[7:0]};
      cnt_d = cnt_q + diff - (qm3[8] ? 5'sd0 : 5'sd2);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q <= '0; cnt_q <= '0;
    end else begin
      out_q <= out_d; cnt_q <= cnt_d;
    end
  end

  assign out_o = out_q;
`ifdef TMDS_DISP_MON_EN
  assign cnt_o = cnt_q;
`endif
endmodule

module tmds_enc_mc #(
  parameter int CH_CNT  = 3,
  parameter int OUT_REG = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [CH_CNT*8-1:0]    px_data_i,
  input  logic                   px_data_valid_i,
  input  logic                   h_sync_i,
  input  logic                   v_sync_i,
  input  logic [2*CH_CNT-1:0]    ctrl_i,
`ifdef TMDS_DISP_MON_EN
  output logic [CH_CNT*5-1:0]    disp_o,
`endif
  output logic [CH_CNT*10-1:0]   tmds_data_o,
  output logic                   tmds_data_valid_o
);
  localparam int STAGES = 3 + OUT_REG;

  logic [STAGES:0] vld_pipe;
  logic [STAGES:1] vld_q;
  logic [1:0]      unused_ctrl;

  assign unused_ctrl = ctrl_i[1:0];   // channel 0 control comes from the syncs
  assign vld_pipe[0] = px_data_valid_i;
  assign vld_pipe[STAGES:1] = vld_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vld_q <= '0;
    else       vld_q <= vld_pipe[STAGES-1:0];
  end

  for (genvar c = 0; c < CH_CNT; c++) begin : g_lane
    logic [1:0] ctl;
    if (c == 0) begin : g_sync
      assign ctl = {v_sync_i, h_sync_i};
    end else begin : g_ctl
      assign ctl = ctrl_i[2*c +: 2];
    end
    tmds_lane #(.OUT_REG(OUT_REG)) u_lane (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (px_data_i[8*c +: 8]),
      .c_i   (ctl),
      .vld_i (vld_pipe[STAGES-1]),
`ifdef TMDS_DISP_MON_EN
      .cnt_o (disp_o[5*c +: 5]),
`endif
      .out_o (tmds_data_o[10*c +: 10])
    );
  end

  assign tmds_data_valid_o = vld_pipe[STAGES];
endmodule

// File: tb/tb_tmds_enc_mc.sv
// Scoreboard bench for tmds_enc_mc: both latencies (OUT_REG=1/0) run side by side on shared stimulus.
module tb_tmds_enc_mc;
  localparam int CH = 3;
  localparam int W  = CH * 10 + 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [CH*8-1:0]  px   = '0;
  logic             pv   = 1'b0;
  logic             hs   = 1'b0;
  logic             vs   = 1'b0;
  logic [2*CH-1:0]  ctrl = '0;
  logic [CH*10-1:0] d1, d0;
  logic             v1, v0;
`ifdef TMDS_DISP_MON_EN
  logic [CH*5-1:0]  m1, m0;
`endif

  tmds_enc_mc #(.CH_CNT(CH), .OUT_REG(1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .px_data_i(px), .px_data_valid_i(pv),
    .h_sync_i(hs), .v_sync_i(vs), .ctrl_i(ctrl),
`ifdef TMDS_DISP_MON_EN
    .disp_o(m1),
`endif
    .tmds_data_o(d1), .tmds_data_valid_o(v1));

  tmds_enc_mc #(.CH_CNT(CH), .OUT_REG(0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .px_data_i(px), .px_data_valid_i(pv),
    .h_sync_i(hs), .v_sync_i(vs), .ctrl_i(ctrl),
`ifdef TMDS_DISP_MON_EN
    .disp_o(m0),
`endif
    .tmds_data_o(d0), .tmds_data_valid_o(v0));

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int               due;
    logic [CH*10-1:0] data;
    logic             vld;
    logic [CH*5-1:0]  disp;
  } exp_t;

  exp_t sb1[$];
  exp_t sb0[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   mcnt[CH];

  task automatic cmp(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, exp);
  endtask

  // Reference encoder straight from the TMDS rules, disparity kept as a plain int.
  function automatic logic [9:0] enc_ch(input int c, input logic [7:0] d, input logic v,
                                        input logic [1:0] cc);
    logic [8:0] qm;
    logic [9:0] r;
    logic       xn;
    int         n1, n0;
    if (!v) begin
      mcnt[c] = 0;
      case (cc)
        2'b00:   return 10'h354;
        2'b01:   return 10'h0AB;
        2'b10:   return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    xn = ($countones(d) > 4) || ($countones(d) == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (mcnt[c] == 0 || n1 == n0) begin
      r = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      mcnt[c] += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((mcnt[c] > 0 && n1 > n0) || (mcnt[c] < 0 && n0 > n1)) begin
      r = {1'b1, qm[8], ~qm[7:0]};
      mcnt[c] += 2 * int'(qm[8]) + (n0 - n1);
    end else begin
      r = {1'b0, qm[8], qm[7:0]};
      mcnt[c] += (n1 - n0) - 2 * int'(!qm[8]);
    end
    return r;
  endfunction

  task automatic drive(input logic [CH*8-1:0] d, input logic v, input logic h,
                       input logic vsy, input logic [2*CH-1:0] ct);
    exp_t e;
    logic [1:0] cc;
    px = d; pv = v; hs = h; vs = vsy; ctrl = ct;
    for (int c = 0; c < CH; c++) begin
      cc = (c == 0) ? {vsy, h} : ct[2*c +: 2];
      e.data[10*c +: 10] = enc_ch(c, d[8*c +: 8], v, cc);
      e.disp[5*c +: 5]   = 5'(mcnt[c]);
    end
    e.vld = v;
    e.due = cyc + 1 + 3; sb1.push_back(e);
    e.due = cyc + 1 + 2; sb0.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic do_reset(input int hold);
    exp_t e;
    rst_i = 1'b1;
    #1;
    cmp("reset_out_L4", {v1, d1}, '0);
    cmp("reset_out_L3", {v0, d0}, '0);
    sb1.delete(); sb0.delete();
    for (int c = 0; c < CH; c++) mcnt[c] = 0;
    repeat (hold) @(negedge clk_i);
    rst_i = 1'b0;
    e.data = {CH{10'h354}}; e.vld = 1'b0; e.disp = '0;
    for (int k = 1; k <= 3; k++) begin e.due = cyc + k; sb1.push_back(e); end
    for (int k = 1; k <= 2; k++) begin e.due = cyc + k; sb0.push_back(e); end
  endtask

  // Monitor: compares whichever expected word is due at this cycle.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (sb1.size() > 0 && sb1[0].due <= cyc) begin
        if (sb1[0].due < cyc) cmp("stale_L4", W'(sb1[0].due), W'(cyc));
        else begin
          cmp("word_L4", {v1, d1}, {sb1[0].vld, sb1[0].data});
`ifdef TMDS_DISP_MON_EN
          cmp("disp_L4", W'(m1), W'(sb1[0].disp));
`endif
        end
        void'(sb1.pop_front());
      end
      if (sb0.size() > 0 && sb0[0].due <= cyc) begin
        if (sb0[0].due < cyc) cmp("stale_L3", W'(sb0[0].due), W'(cyc));
        else begin
          cmp("word_L3", {v0, d0}, {sb0[0].vld, sb0[0].data});
`ifdef TMDS_DISP_MON_EN
          cmp("disp_L3", W'(m0), W'(sb0[0].disp));
`endif
        end
        void'(sb0.pop_front());
      end
    end
  end

  task automatic rand_run(input int n);
    logic v;
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(0, 7) != 0);
      drive(CH*8'($urandom()) ^ {$urandom(), $urandom()} >> 0, v,
            1'($urandom()), 1'($urandom()), 6'($urandom()));
    end
  endtask

  initial begin
    @(negedge clk_i);
    do_reset(2);
    repeat (4) drive('0, 1'b0, 1'b0, 1'b0, '0);
    repeat (4) drive('0, 1'b0, 1'b1, 1'b0, 6'b10_11_00);
    repeat (3) drive({CH{8'h00}}, 1'b1, 1'b0, 1'b0, '0);
    drive('0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) drive({CH{8'hFF}}, 1'b1, 1'b0, 1'b0, '0);
    drive('0, 1'b0, 1'b0, 1'b0, '0);
    drive({CH{8'h00}}, 1'b1, 1'b0, 1'b0, '0);
    drive('0, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) drive({CH{8'h00}}, 1'b1, 1'b0, 1'b0, '0);
    rand_run(300);
    repeat (3) drive({CH{8'h00}}, 1'b1, 1'b0, 1'b0, '0);
    do_reset(1);
    repeat (3) drive({CH{8'h00}}, 1'b1, 1'b0, 1'b0, '0);
    rand_run(300);
    repeat (6) drive('0, 1'b0, 1'b0, 1'b1, '0);
    repeat (6) @(negedge clk_i);
    cmp("scoreboard_drained", W'(sb1.size() + sb0.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
